// File: rtl/riscv_defines.sv
// Shared type definitions for the kianv pipeline: load/store operation
// encodings and the memory-stage bus FSM states.
package riscv_defines;

  typedef enum logic [2:0] {
    LOAD_OP_NONE = 3'd0,
    LOAD_OP_LB   = 3'd1,
    LOAD_OP_LH   = 3'd2,
    LOAD_OP_LW   = 3'd3,
    LOAD_OP_LBU  = 3'd4,
    LOAD_OP_LHU  = 3'd5
  } LoadOp_t;

  typedef enum logic [1:0] {
    STORE_OP_NONE = 2'd0,
    STORE_OP_SB   = 2'd1,
    STORE_OP_SH   = 2'd2,
    STORE_OP_SW   = 2'd3
  } StoreOp_t;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_WAIT  = 2'd1,
    MEM_DRAIN = 2'd2
  } mem_state_t;

  // Halfword loads need an even address, word loads a 4-byte aligned one.
  function automatic logic load_misaligned(input LoadOp_t op, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      LOAD_OP_LH, LOAD_OP_LHU: mis = addr_lo[0];
      LOAD_OP_LW:              mis = |addr_lo;
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_stage_store_alignment.sv
// Store formatting: replicates store data across the word, builds byte
// enables from the low address bits and flags misaligned stores.
// Counterpart of load_alignment in writeback.
module store_alignment
  import riscv_defines::*;
(
  input  logic [1:0]  addr_lo,
  input  StoreOp_t    store_op,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned
);

  // Replicate the store lanes so the slave can pick any byte lane via wstrb.
  always_comb begin
    wdata      = data;
    wstrb      = 4'b0000;
    misaligned = 1'b0;
    case (store_op)
      STORE_OP_SB: begin
        wdata = {4{data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      STORE_OP_SH: begin
        wdata      = {2{data[15:0]}};
        wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
        misaligned = addr_lo[0];
      end
      STORE_OP_SW: begin
        wdata      = data;
        wstrb      = 4'b1111;
        misaligned = |addr_lo;
      end
      default: begin
        wdata      = data;
        wstrb      = 4'b0000;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on a valid/ready data
// bus, stalls the pipeline while a transaction is outstanding and owns the
// M->W pipeline register feeding writeback.
//
// state     | meaning
// MEM_IDLE  | no outstanding request; request issued combinationally from M
// MEM_WAIT  | request outstanding, M held by stall, bus fields come from M
// MEM_DRAIN | request orphaned by a flush; replayed from a registered copy
module memory_access_stage
  import riscv_defines::*;
#(
  parameter bit TRAP_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AluResultM,
  input  logic [31:0] WriteDataM,
  input  LoadOp_t     LoadOpM,
  input  StoreOp_t    StoreOpM,
  input  logic        RegWriteM,
  input  logic [4:0]  RdM,
  input  logic        ValidM,
  input  logic        FlushM,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic [31:0] AluResultW,
  output LoadOp_t     LoadOpW,
  output logic [31:0] ReadDataW,
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic        MisalignedW
);

  mem_state_t  state, state_next;
  logic        mem_valid_c, stall_c;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        st_misaligned;
  logic        misaligned, trap_mis, is_mem, access, load_complete;
  logic [31:0] req_addr_c, req_addr_q, req_wdata_q;
  logic [3:0]  req_wstrb_c, req_wstrb_q;

  store_alignment u_store_alignment (
    .addr_lo    (AluResultM[1:0]),
    .store_op   (StoreOpM),
    .data       (WriteDataM),
    .wdata      (st_wdata),
    .wstrb      (st_wstrb),
    .misaligned (st_misaligned)
  );

  assign misaligned  = st_misaligned | load_misaligned(LoadOpM, AluResultM[1:0]);
  assign trap_mis    = misaligned & TRAP_MISALIGNED;
  assign is_mem      = (LoadOpM != LOAD_OP_NONE) | (StoreOpM != STORE_OP_NONE);
  assign access      = ValidM & ~FlushM & is_mem & ~trap_mis;
  assign req_addr_c  = {AluResultM[31:2], 2'b00};
  assign req_wstrb_c = (StoreOpM != STORE_OP_NONE) ? st_wstrb : 4'b0000;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_next;
  end

  // Next state, bus valid and stall decode.
  always_comb begin
    state_next  = state;
    mem_valid_c = 1'b0;
    stall_c     = 1'b0;
    case (state)
      MEM_IDLE: begin
        mem_valid_c = access;
        if (access && !mem_ready) begin
          stall_c    = 1'b1;
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        mem_valid_c = 1'b1;
        stall_c     = ~mem_ready;
        if (mem_ready)   state_next = MEM_IDLE;
        else if (FlushM) state_next = MEM_DRAIN;
      end
      MEM_DRAIN: begin
        // Stall through the completing cycle too: M now holds a younger
        // instruction that has not had its own bus access yet.
        mem_valid_c = 1'b1;
        stall_c     = 1'b1;
        if (mem_ready) state_next = MEM_IDLE;
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  // Shadow copy of the request, frozen once the flushed request is draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      req_wstrb_q <= 4'd0;
    end else if (state != MEM_DRAIN) begin
      req_addr_q  <= req_addr_c;
      req_wdata_q <= st_wdata;
      req_wstrb_q <= req_wstrb_c;
    end
  end

  // Reset kills the request and the stall immediately, not at the next edge.
  assign mem_valid = mem_valid_c & ~rst;
  assign StallM    = stall_c & ~rst;
  assign mem_addr  = (state == MEM_DRAIN) ? req_addr_q  : req_addr_c;
  assign mem_wdata = (state == MEM_DRAIN) ? req_wdata_q : st_wdata;
  assign mem_wstrb = (state == MEM_DRAIN) ? req_wstrb_q : req_wstrb_c;

  assign load_complete = ~stall_c & mem_valid_c & mem_ready & ~FlushM &
                         (LoadOpM != LOAD_OP_NONE);

  // M->W pipeline register; a stall inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AluResultW  <= 32'd0;
      LoadOpW     <= LOAD_OP_NONE;
      ReadDataW   <= 32'd0;
      RegWriteW   <= 1'b0;
      RdW         <= 5'd0;
      MisalignedW <= 1'b0;
    end else if (stall_c) begin
      RegWriteW   <= 1'b0;
      MisalignedW <= 1'b0;
      LoadOpW     <= LOAD_OP_NONE;
    end else begin
      AluResultW  <= AluResultM;
      LoadOpW     <= LoadOpM;
      RdW         <= RdM;
      RegWriteW   <= RegWriteM & ValidM & ~FlushM & ~trap_mis;
      MisalignedW <= trap_mis & ValidM & ~FlushM;
      if (load_complete) ReadDataW <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios followed
// by random instructions compared against a transaction-level model.
module tb_memory_access_stage;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AluResultM, WriteDataM;
  LoadOp_t     LoadOpM;
  StoreOp_t    StoreOpM;
  logic        RegWriteM;
  logic [4:0]  RdM;
  logic        ValidM, FlushM;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        StallM;
  logic [31:0] AluResultW, ReadDataW;
  LoadOp_t     LoadOpW;
  logic        RegWriteW, MisalignedW;
  logic [4:0]  RdW;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rdw = 32'd0;

  always #5 clk = ~clk;

  memory_access_stage #(.TRAP_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .AluResultM(AluResultM), .WriteDataM(WriteDataM),
    .LoadOpM(LoadOpM), .StoreOpM(StoreOpM), .RegWriteM(RegWriteM), .RdM(RdM),
    .ValidM(ValidM), .FlushM(FlushM), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .StallM(StallM), .AluResultW(AluResultW),
    .LoadOpW(LoadOpW), .ReadDataW(ReadDataW), .RegWriteW(RegWriteW),
    .RdW(RdW), .MisalignedW(MisalignedW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int access_size(input LoadOp_t lop, input StoreOp_t sop);
    case (lop)
      LOAD_OP_LB, LOAD_OP_LBU: return 1;
      LOAD_OP_LH, LOAD_OP_LHU: return 2;
      LOAD_OP_LW:              return 4;
      default: ;
    endcase
    case (sop)
      STORE_OP_SB: return 1;
      STORE_OP_SH: return 2;
      STORE_OP_SW: return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input int size, input logic [31:0] d);
    if (size == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] model_wstrb(input int size, input logic [31:0] a);
    int off;
    int mask;
    off  = (size == 4) ? 0 : int'(a % 4) - int'(a % 4) % size;
    mask = (1 << size) - 1;
    return 4'(mask << off);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble_chk(input string tag);
    chk({tag, "_bubble_rw"}, 32'(RegWriteW), 32'd0);
    chk({tag, "_bubble_lop"}, 32'(LoadOpW), 32'(LOAD_OP_NONE));
    chk({tag, "_bubble_mis"}, 32'(MisalignedW), 32'd0);
  endtask

  // One instruction through M, with the bus slave answering after 'waits' cycles.
  task automatic do_instr(input string tag, input LoadOp_t lop, input StoreOp_t sop,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic rw, input logic [4:0] rd, input logic valid,
                          input logic flush, input int waits, input logic [31:0] rdata);
    int size;
    logic mis, acc;
    size = access_size(lop, sop);
    mis  = (size != 0) && ((addr % size) != 0);
    acc  = valid && !flush && (size != 0) && !mis;
    AluResultM = addr; WriteDataM = data; LoadOpM = lop; StoreOpM = sop;
    RegWriteM = rw; RdM = rd; ValidM = valid; FlushM = flush;
    if (acc) begin
      for (int k = 0; k <= waits; k++) begin
        mem_ready = (k == waits);
        mem_rdata = (k == waits) ? rdata : $urandom();
        #2;
        chk({tag, "_valid"}, 32'(mem_valid), 32'd1);
        chk({tag, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_stall"}, 32'(StallM), 32'(k < waits));
        chk({tag, "_wstrb"}, 32'(mem_wstrb),
            (sop != STORE_OP_NONE) ? 32'(model_wstrb(size, addr)) : 32'd0);
        if (sop != STORE_OP_NONE) chk({tag, "_wdata"}, mem_wdata, model_wdata(size, data));
        tick();
        if (k < waits) bubble_chk(tag);
      end
      if (lop != LOAD_OP_NONE) exp_rdw = rdata;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom();
      #2;
      chk({tag, "_novalid"}, 32'(mem_valid), 32'd0);
      chk({tag, "_nostall"}, 32'(StallM), 32'd0);
      tick();
    end
    mem_ready = 1'b0;
    chk({tag, "_aluw"}, AluResultW, addr);
    chk({tag, "_lopw"}, 32'(LoadOpW), 32'(lop));
    chk({tag, "_rdw"}, 32'(RdW), 32'(rd));
    chk({tag, "_rww"}, 32'(RegWriteW), 32'(rw && valid && !flush && !mis));
    chk({tag, "_misw"}, 32'(MisalignedW), 32'(mis && valid && !flush));
    chk({tag, "_rdataw"}, ReadDataW, exp_rdw);
  endtask

  initial begin
    rst = 1'b1;
    AluResultM = 0; WriteDataM = 0; LoadOpM = LOAD_OP_NONE; StoreOpM = STORE_OP_NONE;
    RegWriteM = 0; RdM = 0; ValidM = 0; FlushM = 0; mem_ready = 0; mem_rdata = 0;
    #12;
    chk("reset_valid", 32'(mem_valid), 32'd0);
    chk("reset_stall", 32'(StallM), 32'd0);
    chk("reset_aluw", AluResultW, 32'd0);
    chk("reset_lopw", 32'(LoadOpW), 32'(LOAD_OP_NONE));
    chk("reset_rww", 32'(RegWriteW), 32'd0);
    chk("reset_misw", 32'(MisalignedW), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    do_instr("sw0", LOAD_OP_NONE, STORE_OP_SW, 32'h100, 32'hDEADBEEF, 1'b0, 5'd0, 1'b1, 1'b0, 0, 32'h0);
    do_instr("sb3", LOAD_OP_NONE, STORE_OP_SB, 32'h203, 32'h000000A5, 1'b0, 5'd0, 1'b1, 1'b0, 0, 32'h0);
    do_instr("sh2", LOAD_OP_NONE, STORE_OP_SH, 32'h206, 32'h0000BEEF, 1'b0, 5'd0, 1'b1, 1'b0, 1, 32'h0);
    do_instr("lw3", LOAD_OP_LW, STORE_OP_NONE, 32'h40, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0, 3, 32'h12345678);
    do_instr("lhmis", LOAD_OP_LH, STORE_OP_NONE, 32'h41, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0, 0, 32'h0);
    do_instr("swmis", LOAD_OP_NONE, STORE_OP_SW, 32'h102, 32'h1, 1'b0, 5'd0, 1'b1, 1'b0, 0, 32'h0);
    do_instr("idleflush", LOAD_OP_LW, STORE_OP_NONE, 32'h80, 32'h0, 1'b1, 5'd3, 1'b1, 1'b1, 0, 32'h0);

    // Flush while waiting: request must replay unchanged through DRAIN.
    AluResultM = 32'h88; LoadOpM = LOAD_OP_LW; StoreOpM = STORE_OP_NONE;
    RegWriteM = 1; RdM = 5'd4; ValidM = 1; FlushM = 0; mem_ready = 0;
    #2; chk("fl_issue_stall", 32'(StallM), 32'd1);
    tick(); FlushM = 1'b1;
    #2; chk("fl_wait_valid", 32'(mem_valid), 32'd1);
    tick();
    AluResultM = $urandom(); LoadOpM = LOAD_OP_NONE; StoreOpM = STORE_OP_SW;
    ValidM = 1'b0; FlushM = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #2;
      chk("fl_drain_valid", 32'(mem_valid), 32'd1);
      chk("fl_drain_addr", mem_addr, 32'h88);
      chk("fl_drain_wstrb", 32'(mem_wstrb), 32'd0);
      chk("fl_drain_stall", 32'(StallM), 32'd1);
      tick();
      chk("fl_drain_rww", 32'(RegWriteW), 32'd0);
    end
    mem_ready = 1'b0;
    #2; chk("fl_back_idle", 32'(mem_valid), 32'd0);
    chk("fl_back_stall", 32'(StallM), 32'd0);
    tick();

    // Flush and ready together in WAIT: completes, nothing written back.
    AluResultM = 32'h300; WriteDataM = 32'h11223344; LoadOpM = LOAD_OP_NONE;
    StoreOpM = STORE_OP_SW; RegWriteM = 0; ValidM = 1; FlushM = 0; mem_ready = 0;
    tick();
    FlushM = 1'b1; mem_ready = 1'b1;
    #2; chk("flr_valid", 32'(mem_valid), 32'd1);
    chk("flr_stall", 32'(StallM), 32'd0);
    tick();
    chk("flr_rww", 32'(RegWriteW), 32'd0);
    FlushM = 1'b0; ValidM = 1'b0; mem_ready = 1'b0;
    #2; chk("flr_idle", 32'(mem_valid), 32'd0);
    tick();

    // Reset while a load is waiting.
    AluResultM = 32'h44; LoadOpM = LOAD_OP_LW; StoreOpM = STORE_OP_NONE;
    RegWriteM = 1; RdM = 5'd6; ValidM = 1; FlushM = 0; mem_ready = 0;
    tick();
    #1; rst = 1'b1; #1;
    chk("rstw_valid", 32'(mem_valid), 32'd0);
    chk("rstw_stall", 32'(StallM), 32'd0);
    chk("rstw_aluw", AluResultW, 32'd0);
    chk("rstw_rdataw", ReadDataW, 32'd0);
    chk("rstw_rdw", 32'(RdW), 32'd0);
    exp_rdw = 32'd0;
    tick(); rst = 1'b0;
    do_instr("post_rst", LOAD_OP_LW, STORE_OP_NONE, 32'h44, 32'h0, 1'b1, 5'd6, 1'b1, 1'b0, 1, 32'hCAFEF00D);

    // Random instruction mix.
    for (int n = 0; n < 80; n++) begin
      LoadOp_t  lop;
      StoreOp_t sop;
      int kind;
      kind = $urandom_range(0, 2);
      lop  = (kind == 0) ? LoadOp_t'($urandom_range(1, 5)) : LOAD_OP_NONE;
      sop  = (kind == 1) ? StoreOp_t'($urandom_range(1, 3)) : STORE_OP_NONE;
      do_instr("rand", lop, sop, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 9) == 0), $urandom_range(0, 3), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage directly upstream of the writeback stage in the kianv 5-stage core.
- Issues load/store requests on the data-memory bus with a valid/ready handshake.
- Aligns store data and generates byte-enables, stalls the pipeline while a bus transaction is outstanding, and detects misaligned accesses.
- Owns the M→W pipeline register that feeds AluResultW, LoadOpW and ReadDataW to writeback, which does the load alignment.

Parameters:
- TRAP_MISALIGNED, 1: 1 = misaligned access is suppressed on the bus and flagged via MisalignedW; 0 = issued word-aligned, no flag.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- AluResultM  in  32  effective address / ALU result from execute
- WriteDataM  in  32  rs2 store data
- LoadOpM  in  LoadOp_t  load type; LOAD_OP_NONE when not a load
- StoreOpM  in  StoreOp_t  store type; STORE_OP_NONE when not a store
- RegWriteM  in  1  instruction writes rd
- RdM  in  5  destination register
- ValidM  in  1  M slot holds a real instruction
- FlushM  in  1  kill instruction in M (trap/redirect)
- mem_valid  out  1  bus request valid
- mem_ready  in  1  bus accepts (store) / returns data (load)
- mem_addr  out  32  word-aligned address {AluResultM[31:2],2'b00}
- mem_wdata  out  32  replicated store data
- mem_wstrb  out  4  byte enables; 4'b0000 for loads
- mem_rdata  in  32  raw load data, valid with mem_ready
- StallM  out  1  freeze F/D/E/M stages
- AluResultW  out  32  registered address/result to writeback
- LoadOpW  out  LoadOp_t  registered load type
- ReadDataW  out  32  registered raw memory data
- RegWriteW  out  1  registered write enable
- RdW  out  5  registered rd
- MisalignedW  out  1  registered misaligned-access flag

Behaviour:
- Access = ValidM & ~FlushM & (LoadOpM≠NONE | StoreOpM≠NONE) & ~misaligned.
  - Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- Store formatting:
  - SB: wdata = {4{WriteDataM[7:0]}}, wstrb = 4'b0001<<addr[1:0].
  - SH: wdata = {2{WriteDataM[15:0]}}, wstrb = 4'b0011<<{addr[1],1'b0}.
  - SW: wdata = WriteDataM, wstrb = 4'b1111.
- FSM states IDLE, WAIT, DRAIN; reset → IDLE.
  - IDLE: mem_valid = Access (combinational, 0-wait capable).
    - mem_ready=1 same cycle → complete, no stall.
    - Otherwise StallM=1 and next state WAIT.
  - WAIT: mem_valid=1, StallM=1. M inputs are held stable by the stall, so addr/wdata/wstrb stay stable.
    - mem_ready → IDLE, complete.
    - FlushM=1 while mem_ready=0 → DRAIN.
  - DRAIN: mem_valid=1, StallM=1, request unchanged (a registered copy is kept, since upstream may change after the flush).
    - mem_ready → IDLE; the result is discarded.
- Bus rule: once mem_valid is asserted it is never dropped, and addr/wdata/wstrb never change, until mem_ready.
- W register, updated every cycle when StallM=0:
  - AluResultW←AluResultM, LoadOpW←LoadOpM, RdW←RdM, ReadDataW←mem_rdata (when load completes, else holds).
  - RegWriteW ← RegWriteM & ValidM & ~FlushM & ~(misaligned & TRAP_MISALIGNED).
  - MisalignedW ← misaligned & ValidM & ~FlushM & TRAP_MISALIGNED.
- StallM=1 → bubble into W: RegWriteW=0, MisalignedW=0, LoadOpW=NONE. Other W fields hold.
- Latency: 0-wait access completes the cycle it issues; data is visible in W the next cycle. N wait cycles → N stall cycles.
- Reset, any time including mid-transaction: state IDLE, mem_valid=0, StallM=0, all W outputs 0, LoadOpW=NONE. The bus slave must tolerate an abandoned request on reset.
- A flush in IDLE with no ready prevents issue entirely.
- Simultaneous FlushM and mem_ready in WAIT: completes and discards; next state IDLE.

Decomposition:
- LoadOp_t and StoreOp_t (incl. NONE encodings) stay in the shared riscv_defines package. Add the mem_state_t enum (IDLE/WAIT/DRAIN) there.
- One sub-module, store_alignment (addr[1:0], StoreOp, data → wdata, wstrb, misaligned), is combinational and mirrors load_alignment.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ready tied 1 → mem_addr 0x100, wstrb 1111, no stall; next cycle AluResultW=0x100, RegWriteW=0.
- SB addr 0x203, data 0x000000A5 → wdata 0xA5A5A5A5, wstrb 1000.
- LW addr 0x40, ready after 3 cycles, rdata 0x12345678 → StallM high 3 cycles, W bubbles meanwhile, then ReadDataW=0x12345678, RegWriteW=1.
- LH addr 0x41 with TRAP_MISALIGNED=1 → mem_valid never asserts, next cycle MisalignedW=1, RegWriteW=0.
- LW in WAIT, FlushM pulsed, ready 2 cycles later → mem_valid and addr stable through DRAIN, RegWriteW stays 0, FSM back to IDLE.
- rst asserted during WAIT → mem_valid, StallM and all W outputs 0 immediately (async); first access after release behaves normally.
